// File: rtl/note_display_ctrl.sv
// -----------------------------------------------------------------------------
// note_display_ctrl
//
// Purpose:
//   Takes musical notes (chromatic code + octave) over a valid/ready handshake,
//   buffers one note in a pending register, and presents each note on three
//   seven-segment digit codes (letter, sharp, octave) for HOLD_CYCLES cycles.
//   Every note is followed by GAP_CYCLES blank cycles and one mandatory IDLE
//   cycle before the next note is shown.
//
// Ports:
//   clk         in   1  rising-edge clock for all state
//   reset_n     in   1  asynchronous active-low reset
//   clear       in   1  synchronous abort: drop shown/pending notes, blank
//   note_valid  in   1  note_code/octave pair is offered
//   note_code   in   4  chromatic index 0..11 (C..B); 12..15 illegal
//   octave      in   3  octave number 0..7
//   note_ready  out  1  offer accepted this cycle (= ~pending valid)
//   letter_hex  out  4  letter digit code      letter_en  out 1  enable
//   sharp_hex   out  4  sharp digit code       sharp_en   out 1  enable
//   oct_hex     out  4  octave digit code      oct_en     out 1  enable
//   busy        out  1  state is not IDLE or a note is pending
//   err         out  1  one-cycle pulse after an illegal code is accepted
// -----------------------------------------------------------------------------
module note_display_ctrl #(
    parameter int HOLD_CYCLES = 25_000_000,
    parameter int GAP_CYCLES  = 2_500_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clear,
    input  logic       note_valid,
    input  logic [3:0] note_code,
    input  logic [2:0] octave,
    output logic       note_ready,
    output logic [3:0] letter_hex,
    output logic       letter_en,
    output logic [3:0] sharp_hex,
    output logic       sharp_en,
    output logic [3:0] oct_hex,
    output logic       oct_en,
    output logic       busy,
    output logic       err
);

    // Counter sized for the larger dwell; it only ever holds N-1 values.
    localparam int MAX_CYCLES = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

    // Digit code that the seg7 stage renders as "all off / blank".
    localparam logic [3:0] BLANK_HEX = 4'h8;
    localparam logic [3:0] LAST_LEGAL_CODE = 4'd11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // Decode tables: letter digit code and sharp flag per chromatic index.
    // -------------------------------------------------------------------------
    function automatic logic [3:0] letter_of(input logic [3:0] code);
        logic [3:0] hex;
        case (code)
            4'd0, 4'd1:  hex = 4'hC;
            4'd2, 4'd3:  hex = 4'hD;
            4'd4:        hex = 4'hE;
            4'd5, 4'd6:  hex = 4'hF;
            4'd7, 4'd8:  hex = 4'h1;  // G: downstream digit 1 is drawn as "G"
            4'd9, 4'd10: hex = 4'hA;
            4'd11:       hex = 4'hB;
            default:     hex = BLANK_HEX;
        endcase
        return hex;
    endfunction

    function automatic logic sharp_of(input logic [3:0] code);
        return (code == 4'd1) || (code == 4'd3) || (code == 4'd6) ||
               (code == 4'd8) || (code == 4'd10);
    endfunction

    logic [3:0] letter_tab [16];
    logic [15:0] sharp_tab;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_decode
            assign letter_tab[gi] = letter_of(4'(gi));
            assign sharp_tab[gi]  = sharp_of(4'(gi));
        end
    endgenerate

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t           state_reg,      state_next;
    logic [CNT_W-1:0] cnt_reg,        cnt_next;
    logic             pend_valid_reg, pend_valid_next;
    logic [3:0]       pend_code_reg,  pend_code_next;
    logic [2:0]       pend_oct_reg,   pend_oct_next;
    logic [3:0]       letter_hex_reg, letter_hex_next;
    logic             letter_en_reg,  letter_en_next;
    logic [3:0]       sharp_hex_reg,  sharp_hex_next;
    logic             sharp_en_reg,   sharp_en_next;
    logic [3:0]       oct_hex_reg,    oct_hex_next;
    logic             oct_en_reg,     oct_en_next;
    logic             busy_reg,       busy_next;
    logic             err_reg,        err_next;

    logic handshake;
    logic code_legal;

    // Ready depends only on the pending slot, never on state or clear.
    assign note_ready = ~pend_valid_reg;
    assign handshake  = note_valid & note_ready & ~clear;
    assign code_legal = (note_code <= LAST_LEGAL_CODE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            pend_valid_reg <= 1'b0;
            pend_code_reg  <= 4'd0;
            pend_oct_reg   <= 3'd0;
            letter_hex_reg <= BLANK_HEX;
            letter_en_reg  <= 1'b0;
            sharp_hex_reg  <= BLANK_HEX;
            sharp_en_reg   <= 1'b0;
            oct_hex_reg    <= BLANK_HEX;
            oct_en_reg     <= 1'b0;
            busy_reg       <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            pend_valid_reg <= pend_valid_next;
            pend_code_reg  <= pend_code_next;
            pend_oct_reg   <= pend_oct_next;
            letter_hex_reg <= letter_hex_next;
            letter_en_reg  <= letter_en_next;
            sharp_hex_reg  <= sharp_hex_next;
            sharp_en_reg   <= sharp_en_next;
            oct_hex_reg    <= oct_hex_next;
            oct_en_reg     <= oct_en_next;
            busy_reg       <= busy_next;
            err_reg        <= err_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        pend_valid_next = pend_valid_reg;
        pend_code_next  = pend_code_reg;
        pend_oct_next   = pend_oct_reg;
        letter_hex_next = letter_hex_reg;
        letter_en_next  = letter_en_reg;
        sharp_hex_next  = sharp_hex_reg;
        sharp_en_next   = sharp_en_reg;
        oct_hex_next    = oct_hex_reg;
        oct_en_next     = oct_en_reg;
        err_next        = 1'b0;

        case (state_reg)
            IDLE: begin
                if (pend_valid_reg) begin
                    state_next      = SHOW;
                    cnt_next        = HOLD_LOAD;
                    pend_valid_next = 1'b0;
                    letter_hex_next = letter_tab[pend_code_reg];
                    letter_en_next  = 1'b1;
                    if (sharp_tab[pend_code_reg]) begin
                        sharp_hex_next = 4'h0;
                        sharp_en_next  = 1'b1;
                    end else begin
                        sharp_hex_next = BLANK_HEX;
                        sharp_en_next  = 1'b0;
                    end
                    // Octaves 0 and 1 stay dark: those digit codes are
                    // repurposed downstream (1 = G, 0 = sharp sign).
                    if (pend_oct_reg >= 3'd2) begin
                        oct_hex_next = {1'b0, pend_oct_reg};
                        oct_en_next  = 1'b1;
                    end else begin
                        oct_hex_next = BLANK_HEX;
                        oct_en_next  = 1'b0;
                    end
                end
            end
            SHOW: begin
                if (cnt_reg == '0) begin
                    state_next      = GAP;
                    cnt_next        = GAP_LOAD;
                    letter_hex_next = BLANK_HEX;
                    letter_en_next  = 1'b0;
                    sharp_hex_next  = BLANK_HEX;
                    sharp_en_next   = 1'b0;
                    oct_hex_next    = BLANK_HEX;
                    oct_en_next     = 1'b0;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt_reg == '0) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase

        // A handshake can only happen with the pending slot empty, so it never
        // collides with the IDLE->SHOW unload above.
        if (handshake) begin
            if (code_legal) begin
                pend_valid_next = 1'b1;
                pend_code_next  = note_code;
                pend_oct_next   = octave;
            end else begin
                err_next = 1'b1;
            end
        end

        if (clear) begin
            state_next      = IDLE;
            cnt_next        = '0;
            pend_valid_next = 1'b0;
            letter_hex_next = BLANK_HEX;
            letter_en_next  = 1'b0;
            sharp_hex_next  = BLANK_HEX;
            sharp_en_next   = 1'b0;
            oct_hex_next    = BLANK_HEX;
            oct_en_next     = 1'b0;
            err_next        = 1'b0;
        end

        // Registered busy tracks the state/pending values taking effect next.
        busy_next = (state_next != IDLE) || pend_valid_next;
    end

    assign letter_hex = letter_hex_reg;
    assign letter_en  = letter_en_reg;
    assign sharp_hex  = sharp_hex_reg;
    assign sharp_en   = sharp_en_reg;
    assign oct_hex    = oct_hex_reg;
    assign oct_en     = oct_en_reg;
    assign busy       = busy_reg;
    assign err        = err_reg;

endmodule

// File: tb/tb_note_display_ctrl.sv
// -----------------------------------------------------------------------------
// tb_note_display_ctrl
//
// Directed bench for note_display_ctrl with HOLD_CYCLES=4, GAP_CYCLES=2.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// Cycle numbering: "cycle k" is the interval following edge k-1, where edge 0
// is the handshake edge of the note under test.
// -----------------------------------------------------------------------------
module tb_note_display_ctrl;

    logic       clk;
    logic       reset_n;
    logic       clear;
    logic       note_valid;
    logic [3:0] note_code;
    logic [2:0] octave;
    logic       note_ready;
    logic [3:0] letter_hex;
    logic       letter_en;
    logic [3:0] sharp_hex;
    logic       sharp_en;
    logic [3:0] oct_hex;
    logic       oct_en;
    logic       busy;
    logic       err;

    int checks;
    int passed;

    note_display_ctrl #(
        .HOLD_CYCLES(4),
        .GAP_CYCLES (2)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (clear),
        .note_valid (note_valid),
        .note_code  (note_code),
        .octave     (octave),
        .note_ready (note_ready),
        .letter_hex (letter_hex),
        .letter_en  (letter_en),
        .sharp_hex  (sharp_hex),
        .sharp_en   (sharp_en),
        .oct_hex    (oct_hex),
        .oct_en     (oct_en),
        .busy       (busy),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Full display snapshot against expectations.
    task automatic chk_disp(input string tag, input logic [3:0] lh, input logic le,
                            input logic [3:0] sh, input logic se,
                            input logic [3:0] oh, input logic oe);
        chk({tag, ".letter_hex"}, 32'(letter_hex), 32'(lh));
        chk({tag, ".letter_en"},  32'(letter_en),  32'(le));
        chk({tag, ".sharp_hex"},  32'(sharp_hex),  32'(sh));
        chk({tag, ".sharp_en"},   32'(sharp_en),   32'(se));
        chk({tag, ".oct_hex"},    32'(oct_hex),    32'(oh));
        chk({tag, ".oct_en"},     32'(oct_en),     32'(oe));
    endtask

    task automatic chk_blank(input string tag);
        chk_disp(tag, 4'h8, 1'b0, 4'h8, 1'b0, 4'h8, 1'b0);
    endtask

    task automatic chk_reset_values(input string tag);
        chk_blank(tag);
        chk({tag, ".busy"},       32'(busy),       32'd0);
        chk({tag, ".note_ready"}, 32'(note_ready), 32'd1);
        chk({tag, ".err"},        32'(err),        32'd0);
    endtask

    task automatic offer(input logic [3:0] code, input logic [2:0] oct);
        note_valid = 1'b1;
        note_code  = code;
        octave     = oct;
    endtask

    initial begin
        checks     = 0;
        passed     = 0;
        reset_n    = 1'b0;
        clear      = 1'b0;
        note_valid = 1'b0;
        note_code  = 4'd0;
        octave     = 3'd0;

        // ---------------- reset state ----------------
        tick();
        tick();
        chk_reset_values("reset");
        reset_n = 1'b1;
        tick();
        chk_reset_values("post_reset_idle");

        // ---------------- G4: shows cycles 2..5, blank 6..7, IDLE 8 ----------
        offer(4'd7, 3'd4);
        tick();                              // edge 0 handshake -> cycle 1
        note_valid = 1'b0;
        chk("g4.c1.note_ready", 32'(note_ready), 32'd0);
        chk("g4.c1.busy",       32'(busy),       32'd1);
        chk_blank("g4.c1");
        for (int c = 2; c <= 5; c++) begin
            tick();
            chk_disp($sformatf("g4.c%0d", c), 4'h1, 1'b1, 4'h8, 1'b0, 4'h4, 1'b1);
        end
        tick();
        chk_blank("g4.c6");
        chk("g4.c6.busy", 32'(busy), 32'd1);
        tick();
        chk_blank("g4.c7");
        chk("g4.c7.busy", 32'(busy), 32'd1);
        tick();
        chk("g4.c8.busy", 32'(busy), 32'd0);
        chk_blank("g4.c8");

        // ---------------- A#1: sharp shown, octave 1 dark ----------------
        offer(4'd10, 3'd1);
        tick();
        note_valid = 1'b0;
        tick();                              // cycle 2
        chk_disp("as1.c2", 4'hA, 1'b1, 4'h0, 1'b1, 4'h8, 1'b0);
        for (int c = 3; c <= 8; c++) tick();
        chk("as1.c8.busy", 32'(busy), 32'd0);

        // ---------------- B3 then C5 on back-to-back edges ----------------
        offer(4'd11, 3'd3);
        tick();                              // edge 0: B3 accepted -> cycle 1
        chk("b3.c1.note_ready", 32'(note_ready), 32'd0);
        offer(4'd0, 3'd5);                   // C5 offered and held
        tick();                              // edge 1: refused, B3 -> SHOW
        chk("b3.c2.note_ready", 32'(note_ready), 32'd1);
        chk_disp("b3.c2", 4'hB, 1'b1, 4'h8, 1'b0, 4'h3, 1'b1);
        tick();                              // edge 2: C5 accepted -> cycle 3
        note_valid = 1'b0;
        chk("c5.c3.note_ready", 32'(note_ready), 32'd0);
        tick();
        tick();                              // cycle 5
        chk_disp("b3.c5", 4'hB, 1'b1, 4'h8, 1'b0, 4'h3, 1'b1);
        tick();
        chk_blank("b3.c6");
        tick();
        chk_blank("b3.c7");
        tick();                              // cycle 8: IDLE, C5 pending
        chk_blank("b3.c8");
        chk("b3.c8.busy", 32'(busy), 32'd1);
        tick();                              // cycle 9
        chk_disp("c5.c9", 4'hC, 1'b1, 4'h8, 1'b0, 4'h5, 1'b1);
        chk("c5.c9.note_ready", 32'(note_ready), 32'd1);
        tick();
        tick();
        tick();                              // cycle 12
        chk_disp("c5.c12", 4'hC, 1'b1, 4'h8, 1'b0, 4'h5, 1'b1);
        tick();                              // cycle 13
        chk_blank("c5.c13");
        tick();
        tick();                              // cycle 15
        chk("c5.c15.busy", 32'(busy), 32'd0);

        // ---------------- illegal code 13 ----------------
        offer(4'd13, 3'd2);
        tick();
        note_valid = 1'b0;
        chk("ill.c1.err",        32'(err),        32'd1);
        chk("ill.c1.busy",       32'(busy),       32'd0);
        chk("ill.c1.note_ready", 32'(note_ready), 32'd1);
        tick();
        chk("ill.c2.err",  32'(err),  32'd0);
        chk("ill.c2.busy", 32'(busy), 32'd0);
        chk_blank("ill.c2");

        // ---------------- G0: octave 0 dark ----------------
        offer(4'd7, 3'd0);
        tick();
        note_valid = 1'b0;
        tick();
        chk_disp("g0.c2", 4'h1, 1'b1, 4'h8, 1'b0, 4'h8, 1'b0);
        for (int c = 3; c <= 8; c++) tick();
        chk("g0.c8.busy", 32'(busy), 32'd0);

        // ---------------- clear during SHOW with a pending note ----------------
        offer(4'd3, 3'd6);
        tick();
        note_valid = 1'b0;
        tick();                              // cycle 2: D#6 shown
        chk_disp("ds6.c2", 4'hD, 1'b1, 4'h0, 1'b1, 4'h6, 1'b1);
        offer(4'd4, 3'd2);
        tick();                              // E2 pending
        chk("clr.pre.note_ready", 32'(note_ready), 32'd0);
        clear = 1'b1;
        offer(4'd5, 3'd3);                   // ignored because of clear
        tick();
        chk_blank("clr.after");
        chk("clr.after.note_ready", 32'(note_ready), 32'd1);
        chk("clr.after.busy",       32'(busy),       32'd0);
        clear      = 1'b0;
        note_valid = 1'b0;
        tick();
        tick();
        chk_blank("clr.later");
        chk("clr.later.busy", 32'(busy), 32'd0);

        // ---------------- reset pulsed mid-GAP ----------------
        offer(4'd6, 3'd7);
        tick();
        note_valid = 1'b0;
        tick();                              // cycle 2
        chk_disp("fs7.c2", 4'hF, 1'b1, 4'h0, 1'b1, 4'h7, 1'b1);
        offer(4'd9, 3'd2);
        tick();                              // cycle 3, A2 pending
        note_valid = 1'b0;
        tick();
        tick();
        tick();                              // cycle 6: GAP
        chk("rst.gap.busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #2;
        chk_reset_values("rst.async");
        tick();
        chk_reset_values("rst.held");
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) tick();
        chk_blank("rst.after");
        chk("rst.after.busy", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
